// File: rtl/logo_pkg.sv
// Shared types and geometry for the title / game-over logo overlay.
package logo_pkg;

  typedef enum logic [1:0] {
    MODE_NONE     = 2'd0,
    MODE_TITLE    = 2'd1,
    MODE_GAMEOVER = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_TITLE_SCROLL,
    ST_TITLE_HOLD,
    ST_OVER_BLINK,
    ST_OVER_HOLD
  } logo_state_t;

  localparam int TITLE_W = 96;
  localparam int OVER_W  = 128;
  localparam int LOGO_H  = 16;
  localparam int MAX_W   = OVER_W;

endpackage

// File: rtl/logo_pixel_pipe.sv
// Window compare, ROM row addressing and 2-stage bit-select pipeline shared by both logos.
// Row words arrive left-aligned on a MAX_W-bit bus so one bit-select serves both widths.
module logo_pixel_pipe
  import logo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_vis,
  input  logic [9:0]       i_draw_x,
  input  logic [9:0]       i_draw_y,
  input  logic [9:0]       i_org_x,
  input  logic [9:0]       i_org_y,
  input  logic [7:0]       i_width,
  input  logic [23:0]      i_rgb,
  input  logic [MAX_W-1:0] i_row,
  output logic [3:0]       o_addr,
  output logic             o_on,
  output logic [23:0]      o_rgb
);

  localparam int DX_W = $clog2(MAX_W);

  logic [10:0]      w_dx;
  logic [10:0]      w_dy;
  logic             w_in_win;
  logic             w_bit;
  logic [MAX_W-1:0] r_row;
  logic [DX_W-1:0]  r_dx;
  logic             r_valid;
  logic [23:0]      r_rgb;
  logic             r_on;
  logic [23:0]      r_out_rgb;

  // Bit 10 of each difference flags a pixel left of / above the logo origin.
  assign w_dx     = {1'b0, i_draw_x} - {1'b0, i_org_x};
  assign w_dy     = {1'b0, i_draw_y} - {1'b0, i_org_y};
  assign w_in_win = i_en
                 && !w_dx[10] && (w_dx[9:0] < {2'b00, i_width})
                 && !w_dy[10] && (w_dy[9:0] < 10'(LOGO_H));
  assign o_addr   = w_in_win ? w_dy[3:0] : 4'd0;
  assign w_bit    = r_row[DX_W'(MAX_W - 1) - r_dx];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order; every flop here is reset, including
  // the row word, so nothing stale leaks out of the pipeline after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_dx      <= '0;
      r_valid   <= 1'b0;
      r_rgb     <= '0;
      r_on      <= 1'b0;
      r_out_rgb <= '0;
    end else begin
      r_row     <= i_row;
      r_dx      <= w_dx[DX_W-1:0];
      r_valid   <= w_in_win && i_vis;
      r_rgb     <= i_rgb;
      r_on      <= r_valid && w_bit;
      r_out_rgb <= (r_valid && w_bit) ? r_rgb : 24'h0;
    end
  end

  assign o_on  = r_on;
  assign o_rgb = r_out_rgb;

endmodule

// File: rtl/logo_overlay.sv
// Title-scroll / game-over-blink overlay: per-frame animation FSM driving a shared
// pixel pipeline with the active logo origin, width and colour.
module logo_overlay
  import logo_pkg::*;
#(
  parameter int          SCREEN_H     = 480,
  parameter int          TITLE_X      = 272,
  parameter int          TITLE_Y      = 100,
  parameter int          OVER_X       = 256,
  parameter int          OVER_Y       = 232,
  parameter int          SCROLL_STEP  = 4,
  parameter int          BLINK_FRAMES = 128,
  parameter logic [23:0] TITLE_RGB    = 24'h00A0FF,
  parameter logic [23:0] OVER_RGB     = 24'hFF2020
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_start,
  input  logic [1:0]    mode,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  output logic [3:0]    galaga_addr,
  input  logic [95:0]   galaga_data,
  output logic [3:0]    gameover_addr,
  input  logic [127:0]  gameover_data,
  output logic          logo_on,
  output logic [23:0]   logo_rgb,
  output logic          title_done,
  output logic          over_done
);

  localparam int CNT_W = $clog2(BLINK_FRAMES);

  logo_state_t      r_state;
  logic [9:0]       r_logo_y;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_title_done;
  logic             r_over_done;

  logic [10:0]      w_next_y;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_title_act;
  logic             w_over_act;
  logic             w_visible;
  logic [9:0]       w_org_x;
  logic [9:0]       w_org_y;
  logic [7:0]       w_width;
  logic [23:0]      w_rgb;
  logic [MAX_W-1:0] w_row;
  logic [3:0]       w_addr;

  assign w_next_y   = {1'b0, r_logo_y} - 11'(SCROLL_STEP);
  assign w_next_cnt = r_frame_cnt + CNT_W'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_OFF;
      r_logo_y     <= 10'(SCREEN_H);
      r_frame_cnt  <= '0;
      r_title_done <= 1'b0;
      r_over_done  <= 1'b0;
    end else begin
      r_title_done <= 1'b0;
      r_over_done  <= 1'b0;
      if (frame_start) begin
        if (mode == MODE_TITLE) begin
          if (r_state == ST_TITLE_SCROLL) begin
            if ($signed(w_next_y) <= $signed(11'(TITLE_Y))) begin
              r_logo_y     <= 10'(TITLE_Y);
              r_state      <= ST_TITLE_HOLD;
              r_title_done <= 1'b1;
            end else begin
              r_logo_y <= w_next_y[9:0];
            end
          end else if (r_state != ST_TITLE_HOLD) begin
            r_state  <= ST_TITLE_SCROLL;
            r_logo_y <= 10'(SCREEN_H);
          end
        end else if (mode == MODE_GAMEOVER) begin
          if (r_state == ST_OVER_BLINK) begin
            r_frame_cnt <= w_next_cnt;
            if (w_next_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
              r_state     <= ST_OVER_HOLD;
              r_over_done <= 1'b1;
            end
          end else if (r_state != ST_OVER_HOLD) begin
            r_state     <= ST_OVER_BLINK;
            r_frame_cnt <= '0;
          end
        end else begin
          // NONE and the reserved encoding 3 both blank the overlay.
          r_state  <= ST_OFF;
          r_logo_y <= 10'(SCREEN_H);
        end
      end
    end
  end

  assign w_title_act = (r_state == ST_TITLE_SCROLL) || (r_state == ST_TITLE_HOLD);
  assign w_over_act  = (r_state == ST_OVER_BLINK) || (r_state == ST_OVER_HOLD);
  assign w_visible   = w_title_act || (r_state == ST_OVER_HOLD)
                    || ((r_state == ST_OVER_BLINK) && !r_frame_cnt[4]);

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_org_x = 10'(TITLE_X);
    w_org_y = r_logo_y;
    w_width = 8'(TITLE_W);
    w_rgb   = TITLE_RGB;
    w_row   = {galaga_data, {(MAX_W - TITLE_W){1'b0}}};
    if (w_over_act) begin
      w_org_x = 10'(OVER_X);
      w_org_y = 10'(OVER_Y);
      w_width = 8'(OVER_W);
      w_rgb   = OVER_RGB;
      w_row   = gameover_data;
    end
  end

  logo_pixel_pipe u_pipe (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .i_en     (w_title_act || w_over_act),
    .i_vis    (w_visible),
    .i_draw_x (DrawX),
    .i_draw_y (DrawY),
    .i_org_x  (w_org_x),
    .i_org_y  (w_org_y),
    .i_width  (w_width),
    .i_rgb    (w_rgb),
    .i_row    (w_row),
    .o_addr   (w_addr),
    .o_on     (logo_on),
    .o_rgb    (logo_rgb)
  );

  assign galaga_addr   = w_title_act ? w_addr : 4'd0;
  assign gameover_addr = w_over_act  ? w_addr : 4'd0;
  assign title_done    = r_title_done;
  assign over_done     = r_over_done;

endmodule

// File: tb/tb_logo_overlay.sv
// Self-checking bench for logo_overlay: scoreboard for the pixel path, inline checks
// for addresses, done pulses and reset behaviour.
module tb_logo_overlay;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         frame_start = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [9:0]   DrawX = 10'd0;
  logic [9:0]   DrawY = 10'd0;
  logic [3:0]   galaga_addr;
  logic [95:0]  galaga_data;
  logic [3:0]   gameover_addr;
  logic [127:0] gameover_data;
  logic         logo_on;
  logic [23:0]  logo_rgb;
  logic         title_done;
  logic         over_done;

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_q[$];
  logic sent_now = 1'b0;
  logic sent_d1  = 1'b0;
  logic sent_d2  = 1'b0;

  logo_overlay dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_start   (frame_start),
    .mode          (mode),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .galaga_addr   (galaga_addr),
    .galaga_data   (galaga_data),
    .gameover_addr (gameover_addr),
    .gameover_data (gameover_data),
    .logo_on       (logo_on),
    .logo_rgb      (logo_rgb),
    .title_done    (title_done),
    .over_done     (over_done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [95:0] g_word(input logic [3:0] r);
    return {8'h0F, {11{r, ~r}}};
  endfunction

  function automatic logic [127:0] o_word(input logic [3:0] r);
    return {8'h0F, {15{~r, r}}};
  endfunction

  assign galaga_data   = g_word(galaga_addr);
  assign gameover_data = o_word(gameover_addr);

  // Reference pixel: {on, rgb} for a title logo at row ly and/or a visible game-over logo.
  function automatic logic [24:0] model_px(input int x, input int y, input bit t_en,
                                           input int ly, input bit o_vis);
    logic [95:0]  gw;
    logic [127:0] ow;
    int dx;
    int dy;
    model_px = '0;
    if (t_en) begin
      dx = x - 272;
      dy = y - ly;
      if (dx >= 0 && dx < 96 && dy >= 0 && dy < 16) begin
        gw = g_word(4'(dy));
        if (gw[95 - dx]) model_px = {1'b1, 24'h00A0FF};
      end
    end
    if (o_vis) begin
      dx = x - 256;
      dy = y - 232;
      if (dx >= 0 && dx < 128 && dy >= 0 && dy < 16) begin
        ow = o_word(4'(dy));
        if (ow[127 - dx]) model_px = {1'b1, 24'hFF2020};
      end
    end
  endfunction

  always @(posedge Clk) begin
    sent_d1 <= sent_now;
    sent_d2 <= sent_d1;
  end

  // Scoreboard: each pixel's result is due two edges after it was presented.
  always @(negedge Clk) begin
    logic [24:0] e;
    if (sent_d2) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: output produced with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if ({logo_on, logo_rgb} !== e) begin
          errors++;
          $display("FAIL pixel: got on=%0b rgb=%06h expected on=%0b rgb=%06h at t=%0t",
                   logo_on, logo_rgb, e[24], e[23:0], $time);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_frame();
    @(negedge Clk);
    sent_now    = 1'b0;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic send_px(input int x, input int y, input logic [24:0] e);
    @(negedge Clk);
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    sent_now = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    @(negedge Clk);
    sent_now = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++;
    if ({logo_on, logo_rgb, galaga_addr, gameover_addr, title_done, over_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got on=%0b rgb=%06h ga=%0d oa=%0d td=%0b od=%0b expected all 0",
               logo_on, logo_rgb, galaga_addr, gameover_addr, title_done, over_done);
    end
    Reset_n = 1'b1;
    mode = 2'd1;
    repeat (46) pulse_frame();
    DrawX = 10'd280; DrawY = 10'd303; #1;
    checks++;
    if (galaga_addr !== 4'd3) begin
      errors++; $display("FAIL scroll_at_300: galaga_addr got %0d expected 3", galaga_addr);
    end
    DrawX = 10'd276; DrawY = 10'd302; #1;
    checks++;
    if (galaga_addr !== 4'd2) begin
      errors++; $display("FAIL pre_reset_addr: galaga_addr got %0d expected 2", galaga_addr);
    end
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({logo_on, logo_rgb, galaga_addr, gameover_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid_scroll: got on=%0b rgb=%06h ga=%0d oa=%0d expected all 0",
               logo_on, logo_rgb, galaga_addr, gameover_addr);
    end
    @(negedge Clk);
    checks++;
    if ({logo_on, title_done} !== 2'b00) begin
      errors++; $display("FAIL reset_hold: got on=%0b td=%0b expected 0 0", logo_on, title_done);
    end
    Reset_n = 1'b1;
    send_px(276, 482, model_px(276, 482, 1'b0, 480, 1'b0));
    #1;
    checks++;
    if (galaga_addr !== 4'd0) begin
      errors++; $display("FAIL off_after_reset: galaga_addr got %0d expected 0", galaga_addr);
    end
    drain();
    checks++;
    if (title_done !== 1'b0) begin
      errors++; $display("FAIL no_done_after_reset: title_done got %0b expected 0", title_done);
    end
  endtask

  task automatic test_title_scroll();
    int ly;
    mode = 2'd1;
    for (int k = 1; k <= 99; k++) begin
      pulse_frame();
      ly = (k == 1) ? 480 : (((480 - 4 * (k - 1)) < 100) ? 100 : (480 - 4 * (k - 1)));
      checks++;
      if (title_done !== (k == 96)) begin
        errors++; $display("FAIL title_done_pulse%0d: got %0b expected %0b", k, title_done, (k == 96));
      end
      DrawX = 10'd282; DrawY = 10'(ly + 3); #1;
      checks++;
      if (galaga_addr !== 4'd3) begin
        errors++; $display("FAIL scroll_row_pulse%0d: galaga_addr got %0d expected 3", k, galaga_addr);
      end
      DrawY = 10'(ly - 1); #1;
      checks++;
      if (galaga_addr !== 4'd0) begin
        errors++; $display("FAIL scroll_above_pulse%0d: galaga_addr got %0d expected 0", k, galaga_addr);
      end
      if (k == 96) begin
        @(negedge Clk);
        checks++;
        if (title_done !== 1'b0) begin
          errors++; $display("FAIL title_done_width: got %0b expected 0", title_done);
        end
      end
    end
  endtask

  task automatic test_title_pixels();
    int fx[10] = '{276, 272, 271, 368, 367, 276, 276, 276, 300, 350};
    int fy[10] = '{102, 102, 102, 102, 102,  99, 100, 115, 116, 108};
    int x;
    int y;
    send_px(276, 102, {1'b1, 24'h00A0FF});
    #1;
    checks++;
    if (galaga_addr !== 4'd2) begin
      errors++; $display("FAIL hold_addr: galaga_addr got %0d expected 2", galaga_addr);
    end
    for (int i = 0; i < 10; i++) send_px(fx[i], fy[i], model_px(fx[i], fy[i], 1'b1, 100, 1'b0));
    for (int i = 0; i < 40; i++) begin
      x = 260 + int'($urandom_range(0, 120));
      y = 95 + int'($urandom_range(0, 25));
      send_px(x, y, model_px(x, y, 1'b1, 100, 1'b0));
    end
    drain();
  endtask

  task automatic test_gameover_blink();
    mode = 2'd2;
    for (int f = 0; f <= 129; f++) begin
      pulse_frame();
      checks++;
      if (over_done !== (f == 127)) begin
        errors++; $display("FAIL over_done_frame%0d: got %0b expected %0b", f, over_done, (f == 127));
      end
      send_px(260, 234, model_px(260, 234, 1'b0, 480, (f >= 127) || ((f & 16) == 0)));
      #1;
      checks++;
      if ({gameover_addr, galaga_addr} !== {4'd2, 4'd0}) begin
        errors++; $display("FAIL over_addr_frame%0d: got oa=%0d ga=%0d expected 2 0",
                           f, gameover_addr, galaga_addr);
      end
      send_px(383, 234, model_px(383, 234, 1'b0, 480, (f >= 127) || ((f & 16) == 0)));
      drain();
    end
    mode = 2'd0;
    send_px(260, 234, {1'b1, 24'hFF2020});
    send_px(300, 247, model_px(300, 247, 1'b0, 480, 1'b1));
    drain();
    mode = 2'd2;
  endtask

  task automatic test_switch();
    mode = 2'd1;
    repeat (46) pulse_frame();
    DrawX = 10'd280; DrawY = 10'd303; #1;
    checks++;
    if (galaga_addr !== 4'd3) begin
      errors++; $display("FAIL switch_at_300: galaga_addr got %0d expected 3", galaga_addr);
    end
    mode = 2'd2;
    for (int f = 0; f <= 16; f++) begin
      pulse_frame();
      checks++;
      if ({title_done, over_done} !== 2'b00) begin
        errors++; $display("FAIL switch_done_frame%0d: got td=%0b od=%0b expected 0 0",
                           f, title_done, over_done);
      end
      send_px(276, 302, '0);
      #1;
      checks++;
      if (galaga_addr !== 4'd0) begin
        errors++; $display("FAIL switch_title_addr: galaga_addr got %0d expected 0", galaga_addr);
      end
      send_px(260, 234, model_px(260, 234, 1'b0, 480, f < 16));
      drain();
    end
  endtask

  task automatic test_off_scan();
    int bad;
    mode = 2'd3;
    pulse_frame();
    bad = 0;
    for (int y = 0; y < 480; y++) begin
      if ((y % 16 == 0) || (y >= 100 && y < 116) || (y >= 232 && y < 248)) begin
        for (int x = 0; x < 640; x++) begin
          @(negedge Clk);
          DrawX = 10'(x);
          DrawY = 10'(y);
          if (logo_on || logo_rgb != 24'h0 || galaga_addr != 4'd0 || gameover_addr != 4'd0) bad++;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL off_scan: %0d lit or addressed pixels, expected 0", bad);
    end
    mode = 2'd1;
    repeat (96) pulse_frame();
    send_px(276, 102, {1'b1, 24'h00A0FF});
    drain();
    mode = 2'd0;
    pulse_frame();
    send_px(276, 102, '0);
    #1;
    checks++;
    if (galaga_addr !== 4'd0) begin
      errors++; $display("FAIL none_from_hold: galaga_addr got %0d expected 0", galaga_addr);
    end
    drain();
    mode = 2'd1;
    pulse_frame();
    DrawX = 10'd282; DrawY = 10'd483; #1;
    checks++;
    if (galaga_addr !== 4'd3) begin
      errors++; $display("FAIL title_restart: galaga_addr got %0d expected 3", galaga_addr);
    end
    mode = 2'd2;
    pulse_frame();
    mode = 2'd0;
    pulse_frame();
    send_px(260, 234, '0);
    drain();
  endtask

  initial begin
    test_reset();
    test_title_scroll();
    test_title_pixels();
    test_gameover_blink();
    test_switch();
    test_off_scan();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d expectations never matched", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
